mem_wait_adapter: RTL and testbench

//  Bridges the multicycle core's single unified memory port (Adr/WriteData/MemWrite from

---
 rtl/mem_wait_adapter.sv | 160 ++++++++++++++++
 tb/tb_mem_wait_adapter.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_wait_adapter.sv
// Holds one core memory access on a req/ack bus until it is acknowledged, stalling the controller meanwhile.
// Optional feature macro MEM_TIMEOUT_EN: abort an unanswered request after TIMEOUT cycles with an Err pulse.
module mem_wait_adapter #(
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ReqValid,
  input  logic          ReqWrite,
  input  logic [AW-1:0] ReqAdr,
  input  logic [DW-1:0] ReqWData,
  output logic          Ready,
  output logic [DW-1:0] RData,
  output logic          Stall,
  output logic          Err,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_adr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_ack,
  input  logic [DW-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam logic [DW-1:0] ABORT_DATA = DW'(32'hDEADBEEF);

  if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_timeout
    $error("mem_wait_adapter: TIMEOUT must lie in 2..255");
  end

  state_e          state_q, state_d;
  logic            mem_req_q, mem_req_d;
  logic            mem_we_q, mem_we_d;
  logic [AW-1:0]   mem_adr_q, mem_adr_d;
  logic [DW-1:0]   mem_wdata_q, mem_wdata_d;
  logic [DW-1:0]   rdata_q, rdata_d;
  logic            ready_q, ready_d;
  logic            timeout_hit;

  // Word addressing: the two byte-offset bits never reach the memory bus.
  logic unused_adr_lsbs;
  assign unused_adr_lsbs = ^ReqAdr[1:0];

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: every variable written in a combinational block gets a default first, so no path infers a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (ReqValid) state_d = S_REQ;
      S_REQ:   if (mem_ack || timeout_hit) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_adr_d   = mem_adr_q;
    mem_wdata_d = mem_wdata_q;
    rdata_d     = rdata_q;
    ready_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (ReqValid) begin
          mem_req_d   = 1'b1;
          mem_we_d    = ReqWrite;
          mem_adr_d   = {ReqAdr[AW-1:2], 2'b00};
          mem_wdata_d = ReqWData;
        end
      end
      S_REQ: begin
        // An ack arriving on the last allowed cycle beats the timeout.
        if (mem_ack) begin
          mem_req_d = 1'b0;
          ready_d   = 1'b1;
          if (!mem_we_q) rdata_d = mem_rdata;
        end else if (timeout_hit) begin
          mem_req_d = 1'b0;
          ready_d   = 1'b1;
          if (!mem_we_q) rdata_d = ABORT_DATA;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_adr_q   <= '0;
      mem_wdata_q <= '0;
      rdata_q     <= '0;
      ready_q     <= 1'b0;
    end else begin
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_adr_q   <= mem_adr_d;
      mem_wdata_q <= mem_wdata_d;
      rdata_q     <= rdata_d;
      ready_q     <= ready_d;
    end
  end

`ifdef MEM_TIMEOUT_EN
  logic [7:0] cnt_q, cnt_d;
  logic       err_q;

  assign timeout_hit = (state_q == S_REQ) && !mem_ack && (cnt_q == 8'(TIMEOUT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == S_IDLE && ReqValid) begin
      cnt_d = '0;
    end else if (state_q == S_REQ && !mem_ack && cnt_q != 8'hFF) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= timeout_hit;
    end
  end

  assign Err = err_q;
`else
  assign timeout_hit = 1'b0;
  assign Err         = 1'b0;
`endif

  assign Ready     = ready_q;
  assign RData     = rdata_q;
  assign Stall     = ReqValid & ~ready_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_adr   = mem_adr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_wait_adapter.sv
// Self-checking bench for mem_wait_adapter: per-cycle comparison against a transaction timeline model,
// plus hand-computed literal expectations; honours MEM_TIMEOUT_EN when defined.
`timescale 1ns/1ps
module tb_mem_wait_adapter;

  localparam int AW      = 32;
  localparam int DW      = 32;
  localparam int TIMEOUT = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          ReqValid, ReqWrite;
  logic [AW-1:0] ReqAdr;
  logic [DW-1:0] ReqWData;
  logic          Ready;
  logic [DW-1:0] RData;
  logic          Stall, Err;
  logic          mem_req, mem_we;
  logic [AW-1:0] mem_adr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ack;
  logic [DW-1:0] mem_rdata;

  always #5 clk = ~clk;

  mem_wait_adapter #(.AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .reset     (reset),
    .ReqValid  (ReqValid),
    .ReqWrite  (ReqWrite),
    .ReqAdr    (ReqAdr),
    .ReqWData  (ReqWData),
    .Ready     (Ready),
    .RData     (RData),
    .Stall     (Stall),
    .Err       (Err),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_adr   (mem_adr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit check_en = 1'b0;

  // Expected outputs for the cycle currently in progress, set by the stimulus timeline.
  logic        exp_req, exp_we, exp_ready, exp_err, exp_stall;
  logic [31:0] exp_adr, exp_wdata, exp_rdata;

  // Observation counters, written only by the compare process.
  int          stall_cnt = 0, req_cnt = 0, ready_cnt = 0, err_cnt = 0, last_ready_cyc = -1;
  logic [31:0] last_adr = '0, last_wdata = '0;
  logic        last_we = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      check("mem_req", 32'(mem_req), 32'(exp_req));
      check("ready", 32'(Ready), 32'(exp_ready));
      check("err", 32'(Err), 32'(exp_err));
      check("stall", 32'(Stall), 32'(exp_stall));
      check("rdata", RData, exp_rdata);
      if (exp_req) begin
        check("mem_we", 32'(mem_we), 32'(exp_we));
        check("mem_adr", mem_adr, exp_adr);
        check("mem_wdata", mem_wdata, exp_wdata);
      end
      if (Stall) stall_cnt++;
      if (Ready) begin
        ready_cnt++;
        last_ready_cyc = cyc;
      end
      if (Err) err_cnt++;
      if (mem_req) begin
        req_cnt++;
        last_adr   = mem_adr;
        last_wdata = mem_wdata;
        last_we    = mem_we;
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic set_exp(input logic req, input logic ready, input logic err, input logic stall);
    exp_req   = req;
    exp_ready = ready;
    exp_err   = err;
    exp_stall = stall;
  endtask

  task automatic idle_cycle();
    next_cycle();
    ReqValid  = 1'b0;
    ReqWrite  = 1'($urandom);
    ReqAdr    = $urandom;
    ReqWData  = $urandom;
    mem_ack   = 1'($urandom);
    mem_rdata = $urandom;
    set_exp(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Cycle in which the core raises the request; the adapter is idle and ignores mem_ack.
  task automatic start_access(input bit we, input logic [31:0] adr, input logic [31:0] wd);
    next_cycle();
    ReqValid  = 1'b1;
    ReqWrite  = we;
    ReqAdr    = adr;
    ReqWData  = wd;
    mem_ack   = 1'($urandom);
    mem_rdata = $urandom;
    set_exp(1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic req_cycle(input bit we, input logic [31:0] adr, input logic [31:0] wd,
                           input bit ack, input logic [31:0] rd, input bit scribble, input bit drop);
    next_cycle();
    if (drop) ReqValid = 1'b0;
    if (scribble) begin
      ReqWrite = 1'($urandom);
      ReqAdr   = $urandom;
      ReqWData = $urandom;
    end
    mem_ack   = ack;
    mem_rdata = ack ? rd : $urandom;
    exp_we    = we;
    exp_adr   = adr & 32'hFFFF_FFFC;
    exp_wdata = wd;
    set_exp(1'b1, 1'b0, 1'b0, ReqValid);
  endtask

  task automatic done_cycle(input bit we, input logic [31:0] rd, input bit err);
    next_cycle();
    mem_ack   = 1'($urandom);
    mem_rdata = $urandom;
    if (!we) exp_rdata = rd;
    set_exp(1'b0, 1'b1, err, 1'b0);
  endtask

  // Access acknowledged k wait cycles after mem_req rises; t0 is the request cycle index.
  task automatic run_access(input bit we, input logic [31:0] adr, input logic [31:0] wd,
                            input logic [31:0] rd, input int k, input bit scribble, input bit drop,
                            output int t0);
    start_access(we, adr, wd);
    t0 = cyc;
    for (int j = 1; j <= k + 1; j++) req_cycle(we, adr, wd, (j == k + 1), rd, scribble, drop);
    done_cycle(we, rd, 1'b0);
  endtask

  task automatic run_hold(input int n, output int t0);
    start_access(1'b0, 32'h0000_0A02, 32'h0BAD_0BAD);
    t0 = cyc;
    for (int j = 1; j <= n; j++) req_cycle(1'b0, 32'h0000_0A02, 32'h0BAD_0BAD, 1'b0, '0, 1'b1, 1'b0);
  endtask

  task automatic reset_tail();
    int r0;
    next_cycle();
    reset    = 1'b1;
    ReqValid = 1'b0;
    mem_ack  = 1'b0;
    set_exp(1'b1, 1'b0, 1'b0, 1'b0);
    next_cycle();
    reset     = 1'b0;
    mem_ack   = 1'b1;
    mem_rdata = $urandom;
    exp_rdata = '0;
    set_exp(1'b0, 1'b0, 1'b0, 1'b0);
    r0 = ready_cnt;
    repeat (3) idle_cycle();
    @(negedge clk);
    #1;
    check("t4_no_ready", 32'(ready_cnt - r0), 32'd0);
    check("t4_rdata", RData, 32'h0);
    check("t4_mem_req", 32'(mem_req), 32'd0);
  endtask

  initial begin
    #200_000;
    $display("FAIL watchdog: simulation did not finish within the time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t0, t1, s0, q0, r0, e0, rdy1, k;
    logic [31:0] rd_a, rd_b;

    reset = 1'b1; ReqValid = 1'b0; ReqWrite = 1'b0; ReqAdr = '0; ReqWData = '0;
    mem_ack = 1'b0; mem_rdata = '0;
    exp_we = 1'b0; exp_adr = '0; exp_wdata = '0; exp_rdata = '0;
    set_exp(1'b0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check_en = 1'b1;
    @(negedge clk);
    #1;
    check("rst_mem_adr", mem_adr, 32'h0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    next_cycle();
    reset = 1'b0;
    idle_cycle();

    // Zero-wait load.
    s0 = stall_cnt;
    run_access(1'b0, 32'h0000_1000, 32'h1234_5678, 32'h0050_0113, 0, 1'b0, 1'b0, t0);
    @(negedge clk);
    #1;
    check("t1_stall_cycles", 32'(stall_cnt - s0), 32'd2);
    check("t1_ready_latency", 32'(last_ready_cyc - t0), 32'd2);
    check("t1_rdata", RData, 32'h0050_0113);

    // Store with three wait cycles while the core scribbles on its address/data lines.
    idle_cycle();
    q0 = req_cnt;
    run_access(1'b1, 32'h0000_0067, 32'hCAFE_F00D, 32'h5555_AAAA, 3, 1'b1, 1'b0, t0);
    @(negedge clk);
    #1;
    check("t2_req_cycles", 32'(req_cnt - q0), 32'd4);
    check("t2_ready_latency", 32'(last_ready_cyc - t0), 32'd5);
    check("t2_rdata_kept", RData, 32'h0050_0113);
    check("t2_mem_adr", last_adr, 32'h0000_0064);
    check("t2_mem_we", 32'(last_we), 32'd1);
    check("t3_mem_wdata", last_wdata, 32'hCAFE_F00D);

    // Back-to-back loads with ReqValid held high.
    rd_a = $urandom;
    rd_b = $urandom;
    run_access(1'b0, 32'h0000_0200, $urandom, rd_a, 0, 1'b0, 1'b0, t0);
    @(negedge clk);
    #1;
    rdy1 = last_ready_cyc;
    check("t5_rdata_first", RData, rd_a);
    run_access(1'b0, 32'h0000_0204, $urandom, rd_b, 0, 1'b0, 1'b0, t1);
    @(negedge clk);
    #1;
    check("t5_rdata_second", RData, rd_b);
    check("t5_ready_gap", 32'(last_ready_cyc - rdy1), 32'd3);

    // Ack on the last cycle before a timeout would fire.
    e0 = err_cnt;
    run_access(1'b0, 32'h0000_0300, 32'h0, rd_a, TIMEOUT - 1, 1'b0, 1'b0, t0);
    @(negedge clk);
    #1;
    check("ack_at_limit_err", 32'(err_cnt - e0), 32'd0);
    check("ack_at_limit_rdata", RData, rd_a);

    // ReqValid dropped mid-access: the access still completes.
    r0 = ready_cnt;
    run_access(1'b0, 32'h0000_0400, 32'h0, rd_b, 2, 1'b0, 1'b1, t0);
    @(negedge clk);
    #1;
    check("drop_valid_ready", 32'(ready_cnt - r0), 32'd1);

    for (int i = 0; i < 60; i++) begin
      k = ($urandom_range(0, 9) == 0) ? TIMEOUT - 1 : int'($urandom_range(0, 6));
      run_access(1'($urandom), $urandom, $urandom, $urandom, k, 1'($urandom),
                 ($urandom_range(0, 7) == 0), t0);
      repeat ($urandom_range(0, 2)) idle_cycle();
    end

`ifdef MEM_TIMEOUT_EN
    idle_cycle();
    q0 = req_cnt;
    e0 = err_cnt;
    start_access(1'b0, 32'h0000_0800, 32'h0);
    t0 = cyc;
    for (int j = 1; j <= TIMEOUT; j++) req_cycle(1'b0, 32'h0000_0800, 32'h0, 1'b0, '0, 1'b0, 1'b0);
    done_cycle(1'b0, 32'hDEAD_BEEF, 1'b1);
    @(negedge clk);
    #1;
    check("t6_req_cycles", 32'(req_cnt - q0), 32'd16);
    check("t6_err_pulses", 32'(err_cnt - e0), 32'd1);
    check("t6_ready_latency", 32'(last_ready_cyc - t0), 32'd17);
    check("t6_rdata", RData, 32'hDEAD_BEEF);
    idle_cycle();
    run_hold(3, t0);
    reset_tail();
`else
    idle_cycle();
    e0 = err_cnt;
    r0 = ready_cnt;
    run_hold(40, t0);
    @(negedge clk);
    #1;
    check("t6_req_held", 32'(mem_req), 32'd1);
    check("t6_no_err", 32'(err_cnt - e0), 32'd0);
    check("t6_no_ready", 32'(ready_cnt - r0), 32'd0);
    reset_tail();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
